// File: rtl/i2c_sram_pkg.sv
// Shared state encoding and constants for the I2C-attached 256 x 16 SRAM.
package i2c_sram_pkg;

   localparam int unsigned MEM_DEPTH = 256;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      DEV_ADDR = 4'd1,
      ACK_DEV  = 4'd2,
      MEM_ADDR = 4'd3,
      ACK_MEM  = 4'd4,
      WR_HI    = 4'd5,
      ACK_HI   = 4'd6,
      WR_LO    = 4'd7,
      ACK_LO   = 4'd8,
      RD_HI    = 4'd9,
      MACK_HI  = 4'd10,
      RD_LO    = 4'd11,
      MACK_LO  = 4'd12,
      IGNORE   = 4'd13
   } state_e;

endpackage

// File: rtl/i2c_sram_embedded_if.sv
// Word-access bus between the I2C front-end (master) and the SRAM array (slave).
interface i2c_sram_embedded_if;
   logic        we;
   logic [7:0]  addr;
   logic [15:0] wdata;
   logic [15:0] rdata;

   modport master (output we, addr, wdata, input rdata);
   modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/i2c_sram_embedded_sram.sv
// Single-port synchronous word array; registered read with one cycle of latency.
module sram
   import i2c_sram_pkg::*;
(
   input logic                clk,
   i2c_sram_embedded_if.slave bus
);

   logic [15:0] mem_q [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (bus.we) mem_q[bus.addr] <= bus.wdata;
      bus.rdata <= mem_q[bus.addr];
   end

endmodule

// File: rtl/i2c_sram_embedded.sv
// I2C slave giving word write/read access to an embedded 256 x 16 SRAM.
// Define I2C_SRAM_AUTOINC_EN to advance the word pointer after each completed word.
module i2c_sram_embedded
   import i2c_sram_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   inout  wire         sda,
   input  logic        scl,
   input  logic [6:0]  my_addr,
   output logic [7:0]  curr_data,
   output logic [6:0]  rcvd_device_address,
   output logic        rcvd_mode,
   output logic [32:0] state
);

`ifdef I2C_SRAM_AUTOINC_EN
   localparam logic [7:0] PTR_STEP = 8'd1;
`else
   localparam logic [7:0] PTR_STEP = 8'd0;
`endif

   logic scl_s1_q, scl_s2_q, scl_prev_q;
   logic sda_s1_q, sda_s2_q, sda_prev_q;
   logic scl_rise, scl_fall, start_evt, stop_evt;

   state_e      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [6:0]  shreg_q, shreg_d;
   logic [7:0]  ptr_q, ptr_d;
   logic [7:0]  hi_q, hi_d;
   logic [7:0]  curr_q, curr_d;
   logic [6:0]  dev_q, dev_d;
   logic        mode_q, mode_d;
   logic        we_q, we_d;
   logic [7:0]  waddr_q, waddr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        sda_oe_q, sda_oe_d;

   logic [7:0]  rx_byte, tx_byte;
   logic        last_bit, in_byte;

   i2c_sram_embedded_if mem_bus ();

   sram u_sram (
      .clk (clk),
      .bus (mem_bus)
   );

   // The pointer may already have advanced when the commit cycle happens.
   assign mem_bus.we    = we_q;
   assign mem_bus.addr  = we_q ? waddr_q : ptr_q;
   assign mem_bus.wdata = wdata_q;

   assign sda = sda_oe_q ? 1'b0 : 1'bz;

   assign scl_rise  =  scl_s2_q & ~scl_prev_q;
   assign scl_fall  = ~scl_s2_q &  scl_prev_q;
   assign start_evt =  scl_s2_q &  scl_prev_q &  sda_prev_q & ~sda_s2_q;
   assign stop_evt  =  scl_s2_q &  scl_prev_q & ~sda_prev_q &  sda_s2_q;

   assign rx_byte  = {shreg_q, sda_s2_q};
   assign tx_byte  = (state_q == RD_LO) ? mem_bus.rdata[7:0] : mem_bus.rdata[15:8];
   assign last_bit = (bit_cnt_q == 3'd7);
   assign in_byte  = state_q inside {DEV_ADDR, MEM_ADDR, WR_HI, WR_LO, RD_HI, RD_LO};

   always_ff @(posedge clk) begin
      if (reset) begin
         {scl_s1_q, scl_s2_q, scl_prev_q} <= '1;
         {sda_s1_q, sda_s2_q, sda_prev_q} <= {3{NACK}};
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         ptr_q     <= '0;
         hi_q      <= '0;
         curr_q    <= '0;
         dev_q     <= '0;
         mode_q    <= 1'b0;
         we_q      <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         sda_oe_q  <= 1'b0;
      end else begin
         scl_s1_q   <= scl;
         scl_s2_q   <= scl_s1_q;
         scl_prev_q <= scl_s2_q;
         sda_s1_q   <= sda;
         sda_s2_q   <= sda_s1_q;
         sda_prev_q <= sda_s2_q;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         ptr_q      <= ptr_d;
         hi_q       <= hi_d;
         curr_q     <= curr_d;
         dev_q      <= dev_d;
         mode_q     <= mode_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         sda_oe_q   <= sda_oe_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      ptr_d     = ptr_q;
      hi_d      = hi_q;
      curr_d    = curr_q;
      dev_d     = dev_q;
      mode_d    = mode_q;
      we_d      = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      if (start_evt) begin
         state_d   = DEV_ADDR;
         bit_cnt_d = '0;
      end else if (stop_evt) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
      end else if (scl_rise) begin
         shreg_d   = rx_byte[6:0];
         bit_cnt_d = in_byte ? bit_cnt_q + 3'd1 : '0;
         case (state_q)
            DEV_ADDR: if (last_bit) begin
               dev_d   = rx_byte[7:1];
               mode_d  = rx_byte[0];
               curr_d  = rx_byte;
               state_d = (rx_byte[7:1] == my_addr) ? ACK_DEV : IGNORE;
            end
            ACK_DEV:  state_d = mode_q ? RD_HI : MEM_ADDR;
            MEM_ADDR: if (last_bit) begin
               ptr_d   = rx_byte;
               curr_d  = rx_byte;
               state_d = ACK_MEM;
            end
            ACK_MEM:  state_d = WR_HI;
            WR_HI:    if (last_bit) begin
               hi_d    = rx_byte;
               curr_d  = rx_byte;
               state_d = ACK_HI;
            end
            ACK_HI:   state_d = WR_LO;
            WR_LO:    if (last_bit) begin
               curr_d  = rx_byte;
               we_d    = 1'b1;
               waddr_d = ptr_q;
               wdata_d = {hi_q, rx_byte};
               ptr_d   = ptr_q + PTR_STEP;
               state_d = ACK_LO;
            end
            ACK_LO:   state_d = WR_HI;
            RD_HI:    if (last_bit) begin
               curr_d  = tx_byte;
               state_d = MACK_HI;
            end
            MACK_HI:  state_d = (sda_s2_q == ACK) ? RD_LO : IGNORE;
            RD_LO:    if (last_bit) begin
               curr_d  = tx_byte;
               state_d = MACK_LO;
            end
            MACK_LO: begin
               ptr_d   = ptr_q + PTR_STEP;
               state_d = (sda_s2_q == ACK) ? RD_HI : IGNORE;
            end
            default: ;
         endcase
      end
   end

   // sda only changes on a detected scl fall, using the state entered at the preceding rise.
   always_comb begin
      sda_oe_d = sda_oe_q;
      if (start_evt || stop_evt) begin
         sda_oe_d = 1'b0;
      end else if (scl_fall) begin
         case (state_q)
            ACK_DEV, ACK_MEM, ACK_HI, ACK_LO: sda_oe_d = 1'b1;
            RD_HI, RD_LO: sda_oe_d = (tx_byte[3'd7 - bit_cnt_q] == ACK);
            default: sda_oe_d = 1'b0;
         endcase
      end
   end

   assign state               = 33'(state_q);
   assign curr_data           = curr_q;
   assign rcvd_device_address = dev_q;
   assign rcvd_mode           = mode_q;

endmodule

// File: tb/tb_i2c_sram_embedded.sv
// Directed bench: bit-banged I2C master on an open-drain sda with pull-up.
module tb_i2c_sram_embedded;
   import i2c_sram_pkg::*;

   localparam int Q = 50;

   logic        clk     = 1'b0;
   logic        reset   = 1'b1;
   logic        scl_r   = 1'b1;
   logic        m_rel   = 1'b1;
   logic [6:0]  my_addr = 7'h3C;
   wire         sda;
   logic [7:0]  curr_data;
   logic [6:0]  rcvd_device_address;
   logic        rcvd_mode;
   logic [32:0] state;
   logic [7:0]  d;
   logic        r;
   int unsigned errors = 0;
   int unsigned checks = 0;

   assign sda = m_rel ? 1'bz : 1'b0;
   pullup (sda);

   always #5 clk = ~clk;

   i2c_sram_embedded dut (
      .clk                 (clk),
      .reset               (reset),
      .sda                 (sda),
      .scl                 (scl_r),
      .my_addr             (my_addr),
      .curr_data           (curr_data),
      .rcvd_device_address (rcvd_device_address),
      .rcvd_mode           (rcvd_mode),
      .state               (state)
   );

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bit_xfer(input logic b, output logic rb);
      #Q; m_rel = b; #Q; scl_r = 1'b1; #Q; rb = sda; #Q; scl_r = 1'b0;
   endtask

   task automatic bus_start();
      #Q; m_rel = 1'b1; #Q; scl_r = 1'b1; #Q; m_rel = 1'b0; #Q; scl_r = 1'b0;
   endtask

   task automatic bus_stop();
      #Q; m_rel = 1'b0; #Q; scl_r = 1'b1; #Q; m_rel = 1'b1; #Q;
   endtask

   task automatic put_byte(input logic [7:0] v, input logic exp_ack, input string tag);
      logic rb;
      for (int i = 7; i >= 0; i--) bit_xfer(v[i], rb);
      bit_xfer(1'b1, rb);
      chk(tag, 33'(rb), 33'(exp_ack));
   endtask

   task automatic get_byte(input logic mack, output logic [7:0] v);
      logic rb;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, rb);
         v[i] = rb;
      end
      bit_xfer(mack, rb);
   endtask

   task automatic write_word(input logic [7:0] a, input logic [15:0] w, input string tag);
      bus_start();
      put_byte(8'h78, ACK, {tag, "_dev"});
      put_byte(a, ACK, {tag, "_mem"});
      put_byte(w[15:8], ACK, {tag, "_hi"});
      put_byte(w[7:0], ACK, {tag, "_lo"});
      bus_stop();
   endtask

   // Set the pointer with a write header, then switch to read via repeated START.
   task automatic read_setup(input logic [7:0] a, input string tag);
      bus_start();
      put_byte(8'h78, ACK, {tag, "_wdev"});
      put_byte(a, ACK, {tag, "_mem"});
      bus_start();
      put_byte(8'h79, ACK, {tag, "_rdev"});
   endtask

   task automatic read_word(input logic [7:0] a, input logic [15:0] exp, input string tag);
      logic [7:0] v;
      read_setup(a, tag);
      get_byte(ACK, v);
      chk({tag, "_hi"}, 33'(v), 33'(exp[15:8]));
      get_byte(NACK, v);
      chk({tag, "_lo"}, 33'(v), 33'(exp[7:0]));
      bus_stop();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_state", state, 33'd0);
      chk("rst_curr", 33'(curr_data), 33'h0);
      chk("rst_dev", 33'(rcvd_device_address), 33'h0);
      chk("rst_mode", 33'(rcvd_mode), 33'h0);
      chk("rst_sda", 33'(sda), 33'h1);

      // Write 0x5093 to 0x7C, checking the debug outputs after the last byte.
      bus_start();
      put_byte(8'h78, ACK, "w1_dev");
      put_byte(8'h7C, ACK, "w1_mem");
      put_byte(8'h50, ACK, "w1_hi");
      put_byte(8'h93, ACK, "w1_lo");
      chk("w1_devaddr", 33'(rcvd_device_address), 33'h3C);
      chk("w1_mode", 33'(rcvd_mode), 33'h0);
      chk("w1_curr", 33'(curr_data), 33'h93);
      bus_stop();
      chk("w1_stop_state", state, 33'd0);

      read_setup(8'h7C, "r1");
      get_byte(ACK, d);
      chk("r1_hi", 33'(d), 33'h50);
      get_byte(NACK, d);
      chk("r1_lo", 33'(d), 33'h93);
      chk("r1_mode", 33'(rcvd_mode), 33'h1);
      chk("r1_curr", 33'(curr_data), 33'h93);
      chk("r1_nack_state", state, 33'd13);
      bus_stop();
      chk("r1_stop_state", state, 33'd0);

      write_word(8'h7C, 16'h04D2, "w2");
      read_word(8'h7C, 16'h04D2, "r2");

      // Foreign device address: no ACK anywhere, nothing written.
      bus_start();
      put_byte(8'h7A, NACK, "x_dev");
      chk("x_state", state, 33'd13);
      chk("x_devaddr", 33'(rcvd_device_address), 33'h3D);
      put_byte(8'h7C, NACK, "x_mem");
      put_byte(8'h11, NACK, "x_hi");
      put_byte(8'h22, NACK, "x_lo");
      chk("x_state2", state, 33'd13);
      bus_stop();
      read_word(8'h7C, 16'h04D2, "r3");

      // STOP after the high byte discards the partial word.
      bus_start();
      put_byte(8'h78, ACK, "p_dev");
      put_byte(8'h7C, ACK, "p_mem");
      put_byte(8'hAA, ACK, "p_hi");
      chk("p_wrlo_state", state, 33'd7);
      bus_stop();
      chk("p_stop_state", state, 33'd0);
      read_word(8'h7C, 16'h04D2, "r4");

      // Reset in the middle of the low byte.
      bus_start();
      put_byte(8'h78, ACK, "q_dev");
      put_byte(8'h7C, ACK, "q_mem");
      put_byte(8'hBB, ACK, "q_hi");
      bit_xfer(1'b0, r);
      bit_xfer(1'b1, r);
      bit_xfer(1'b0, r);
      bit_xfer(1'b1, r);
      chk("q_wrlo_state", state, 33'd7);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("q_rst_state", state, 33'd0);
      chk("q_rst_sda", 33'(sda), 33'h1);
      reset = 1'b0;
      bus_stop();
      read_word(8'h7C, 16'h04D2, "r5");

      // Reset while the slave holds sda low for an ACK must release the line.
      bus_start();
      put_byte(8'h78, ACK, "k_dev");
      for (int i = 7; i >= 0; i--) bit_xfer(1'b1, r);
      #Q;
      chk("k_ack_drive", 33'(sda), 33'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("k_rst_sda", 33'(sda), 33'h1);
      chk("k_rst_state", state, 33'd0);
      reset = 1'b0;
      #Q; scl_r = 1'b1; #Q; scl_r = 1'b0;
      bus_stop();

      // Two words at 0xFF, then a two-word read from 0xFF.
      bus_start();
      put_byte(8'h78, ACK, "a_dev");
      put_byte(8'hFF, ACK, "a_mem");
      put_byte(8'h11, ACK, "a_hi1");
      put_byte(8'h11, ACK, "a_lo1");
      put_byte(8'h22, ACK, "a_hi2");
      put_byte(8'h22, ACK, "a_lo2");
      bus_stop();
      read_setup(8'hFF, "ar");
`ifdef I2C_SRAM_AUTOINC_EN
      get_byte(ACK, d);  chk("ar_hi1", 33'(d), 33'h11);
      get_byte(ACK, d);  chk("ar_lo1", 33'(d), 33'h11);
      get_byte(ACK, d);  chk("ar_hi2", 33'(d), 33'h22);
      get_byte(NACK, d); chk("ar_lo2", 33'(d), 33'h22);
      bus_stop();
      read_word(8'h00, 16'h2222, "ar_wrap");
`else
      get_byte(ACK, d);  chk("ar_hi1", 33'(d), 33'h22);
      get_byte(ACK, d);  chk("ar_lo1", 33'(d), 33'h22);
      get_byte(ACK, d);  chk("ar_hi2", 33'(d), 33'h22);
      get_byte(NACK, d); chk("ar_lo2", 33'(d), 33'h22);
      bus_stop();
`endif
      read_word(8'h7C, 16'h04D2, "r6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
